vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 226 ++++++++++++++++++++++
 tb/tb_vga_scanout.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout
//   640x480@60 VGA scan-out engine driving a 64x48-cell frame memory.
//   Each memory cell covers a 10x10 block of screen pixels. The raster
//   position is tracked with h/v counters plus modulo-10 sub-counters, so
//   the cell address needs no divider.
//
//   Pipeline (one pixel per clock):
//     p0 : raster counters and the memory read address for the same pixel.
//          The address register is loaded from the counters' next state, so
//          the memory (one-cycle registered read) returns the cell data in the
//          cycle after the counter stage.
//     p1 : decoded timing flags for the pixel, aligned with mem_data.
//     p2 : registered pins (sync, colour, video_active, frame_start, count).
//
// Ports
//   clk          in   pixel clock (25.175 MHz), one pixel per cycle
//   rst          in   asynchronous active-high reset
//   mem_addr     out  [11:0] frame-memory read address {row[5:0], col[5:0]}
//   mem_data     in   [2:0]  registered read data, one cycle after mem_addr
//   mem_busy     in   memory is writing this cycle; read data not updated
//   hsync/vsync  out  active-low sync pulses
//   red/green/blue out pixel colour, 0 outside the visible area
//   video_active out  high while the output pixel is visible
//   frame_start  out  one-cycle pulse on output pixel (0,0)
//   underrun_cnt out  [7:0] stale-read count for the current frame (saturates)
module vga_scanout (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] mem_addr,
  input  logic [2:0]  mem_data,
  input  logic        mem_busy,
  output logic        hsync,
  output logic        vsync,
  output logic        red,
  output logic        green,
  output logic        blue,
  output logic        video_active,
  output logic        frame_start,
  output logic [7:0]  underrun_cnt
);

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [3:0] SUB_LAST = 4'd9;

  // Saturating increment for the underrun counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Colour selection: blank outside the visible area; a stale read repeats
  // the colour of the previous visible pixel instead of the unrefreshed data.
  function automatic logic [2:0] pick_rgb(input logic       vld,
                                          input logic       stale,
                                          input logic [2:0] fresh,
                                          input logic [2:0] last);
    if (!vld)
      return 3'b000;
    else if (stale)
      return last;
    else
      return fresh;
  endfunction

  // ---------------------------------------------------------------- p0
  logic [9:0]  r_h_cnt_p0;
  logic [9:0]  r_v_cnt_p0;
  logic [3:0]  r_h_sub_p0;
  logic [3:0]  r_v_sub_p0;
  logic [6:0]  r_col_p0;   // reaches 79 in horizontal blanking
  logic [5:0]  r_row_p0;   // reaches 52 in vertical blanking
  logic [11:0] r_addr_p0;

  logic [9:0]  w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic [3:0]  w_h_sub_nxt;
  logic [3:0]  w_v_sub_nxt;
  logic [6:0]  w_col_nxt;
  logic [5:0]  w_row_nxt;
  logic        w_vis_nxt;
  logic        w_vis_p0;
  logic        w_hs_p0;
  logic        w_vs_p0;
  logic        w_fs_p0;

  always_comb begin
    w_h_nxt     = r_h_cnt_p0 + 10'd1;
    w_h_sub_nxt = r_h_sub_p0 + 4'd1;
    w_col_nxt   = r_col_p0;
    w_v_nxt     = r_v_cnt_p0;
    w_v_sub_nxt = r_v_sub_p0;
    w_row_nxt   = r_row_p0;

    if (r_h_sub_p0 == SUB_LAST) begin
      w_h_sub_nxt = 4'd0;
      w_col_nxt   = r_col_p0 + 7'd1;
    end

    if (r_h_cnt_p0 == H_LAST) begin
      w_h_nxt     = 10'd0;
      w_h_sub_nxt = 4'd0;
      w_col_nxt   = 7'd0;
      if (r_v_cnt_p0 == V_LAST) begin
        w_v_nxt     = 10'd0;
        w_v_sub_nxt = 4'd0;
        w_row_nxt   = 6'd0;
      end else begin
        w_v_nxt = r_v_cnt_p0 + 10'd1;
        if (r_v_sub_p0 == SUB_LAST) begin
          w_v_sub_nxt = 4'd0;
          w_row_nxt   = r_row_p0 + 6'd1;
        end else begin
          w_v_sub_nxt = r_v_sub_p0 + 4'd1;
        end
      end
    end
  end

  assign w_vis_nxt = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
  assign w_vis_p0  = (r_h_cnt_p0 < H_VIS) && (r_v_cnt_p0 < V_VIS);
  assign w_hs_p0   = !((r_h_cnt_p0 >= H_SYNC_S) && (r_h_cnt_p0 <= H_SYNC_E));
  assign w_vs_p0   = !((r_v_cnt_p0 >= V_SYNC_S) && (r_v_cnt_p0 <= V_SYNC_E));
  assign w_fs_p0   = (r_h_cnt_p0 == 10'd0) && (r_v_cnt_p0 == 10'd0);

  // The reset address 0 is already the address of pixel (0,0), so the
  // first read after reset release is correct without a warm-up cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt_p0 <= 10'd0;
      r_v_cnt_p0 <= 10'd0;
      r_h_sub_p0 <= 4'd0;
      r_v_sub_p0 <= 4'd0;
      r_col_p0   <= 7'd0;
      r_row_p0   <= 6'd0;
      r_addr_p0  <= 12'd0;
    end else begin
      r_h_cnt_p0 <= w_h_nxt;
      r_v_cnt_p0 <= w_v_nxt;
      r_h_sub_p0 <= w_h_sub_nxt;
      r_v_sub_p0 <= w_v_sub_nxt;
      r_col_p0   <= w_col_nxt;
      r_row_p0   <= w_row_nxt;
      if (w_vis_nxt)
        r_addr_p0 <= {w_row_nxt, w_col_nxt[5:0]};
    end
  end

  // ---------------------------------------------------------------- p1
  logic r_vld_p1;
  logic r_hs_p1;
  logic r_vs_p1;
  logic r_fs_p1;
  logic r_stale_p1;

  // mem_busy is sampled in the same cycle the pixel's address is presented;
  // in blanking it is irrelevant and therefore masked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_hs_p1    <= 1'b1;
      r_vs_p1    <= 1'b1;
      r_fs_p1    <= 1'b0;
      r_stale_p1 <= 1'b0;
    end else begin
      r_vld_p1   <= w_vis_p0;
      r_hs_p1    <= w_hs_p0;
      r_vs_p1    <= w_vs_p0;
      r_fs_p1    <= w_fs_p0;
      r_stale_p1 <= w_vis_p0 & mem_busy;
    end
  end

  // ---------------------------------------------------------------- p2
  logic       r_vld_p2;
  logic       r_hs_p2;
  logic       r_vs_p2;
  logic       r_fs_p2;
  logic [2:0] r_rgb_p2;
  logic [2:0] r_last_rgb;
  logic [7:0] r_ucnt_p2;
  logic [2:0] w_rgb_p1;

  assign w_rgb_p1 = pick_rgb(r_vld_p1, r_stale_p1, mem_data, r_last_rgb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2   <= 1'b0;
      r_hs_p2    <= 1'b1;
      r_vs_p2    <= 1'b1;
      r_fs_p2    <= 1'b0;
      r_rgb_p2   <= 3'b000;
      r_last_rgb <= 3'b000;
      r_ucnt_p2  <= 8'd0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_fs_p2  <= r_fs_p1;
      r_rgb_p2 <= w_rgb_p1;
      if (r_vld_p1)
        r_last_rgb <= w_rgb_p1;
      // frame_start restarts the count; a stale (0,0) pixel counts as the first.
      if (r_fs_p1)
        r_ucnt_p2 <= {7'd0, r_stale_p1};
      else if (r_stale_p1)
        r_ucnt_p2 <= sat_inc8(r_ucnt_p2);
    end
  end

  assign mem_addr     = r_addr_p0;
  assign hsync        = r_hs_p2;
  assign vsync        = r_vs_p2;
  assign video_active = r_vld_p2;
  assign frame_start  = r_fs_p2;
  assign red          = r_rgb_p2[2];
  assign green        = r_rgb_p2[1];
  assign blue         = r_rgb_p2[0];
  assign underrun_cnt = r_ucnt_p2;

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout: scoreboard bench with a registered frame-memory
// model. A driver walks the raster, drives mem_busy, checks mem_addr and
// pushes the expected pin values for each pixel; a monitor pops and compares
// them when the pixel reaches the outputs.
module tb_vga_scanout;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] mem_addr;
  logic [2:0]  mem_data = 3'b000;
  logic        mem_busy = 1'b0;
  logic        hsync, vsync, red, green, blue, video_active, frame_start;
  logic [7:0]  underrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;   // 0: solid green, 1: checkerboard
  bit mon_en   = 1'b0;

  logic [14:0] sb[$];   // {hs, vs, va, fs, r, g, b, ucnt[7:0]}

  // Bench model state
  logic [11:0] m_addr;
  logic [2:0]  m_last_col;
  logic [7:0]  m_uc;

  int          spot_c [7] = '{0, 9, 10, 639, 700, 8000, 8639};
  logic [11:0] spot_a [7] = '{12'd0, 12'd0, 12'd1, 12'd63, 12'd63, 12'd64, 12'd127};

  vga_scanout dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_busy     (mem_busy),
    .hsync        (hsync),
    .vsync        (vsync),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .video_active (video_active),
    .frame_start  (frame_start),
    .underrun_cnt (underrun_cnt)
  );

  always #10 clk = ~clk;

  function automatic logic [2:0] pattern(input logic [11:0] a);
    if (mode == 0)
      return 3'b010;
    else
      return {a[6] ^ a[0], a[0], a[6]};
  endfunction

  // Frame memory: registered read, data frozen while a write is in progress.
  always @(posedge clk) begin
    if (!mem_busy)
      mem_data <= pattern(mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: the pixel issued two cycles ago is on the pins now.
  always @(posedge clk) begin
    #1;
    if (mon_en && sb.size() >= 2) begin
      logic [14:0] e;
      e = sb.pop_front();
      check("pixel_out",
            {17'd0, hsync, vsync, video_active, frame_start, red, green, blue, underrun_cnt},
            {17'd0, e});
    end
  end

  // Called at a negedge: asserts rst between clock edges, checks the reset
  // values before any edge, then releases rst at a later negedge (cycle 0).
  task automatic do_reset();
    rst      = 1'b1;
    mon_en   = 1'b0;
    mem_busy = 1'b0;
    sb.delete();
    #1;
    check("reset_pins",
          {17'd0, hsync, vsync, video_active, frame_start, red, green, blue, underrun_cnt},
          {17'd0, 15'b1100_000_00000000});
    check("reset_addr", {20'd0, mem_addr}, 32'd0);
    repeat (3) @(negedge clk);
    m_addr     = 12'd0;
    m_last_col = 3'b000;
    m_uc       = 8'd0;
    rst        = 1'b0;
    mon_en     = 1'b1;
  endtask

  task automatic cycle_body(input int c, input int blo, input int bhi, input bit spots);
    int h, v;
    logic vis, busy, hs, vs, fs;
    logic [2:0] col;
    h    = c % 800;
    v    = (c / 800) % 525;
    vis  = (h < 640) && (v < 480);
    busy = (c >= blo) && (c <= bhi);
    mem_busy = busy;
    if (vis)
      m_addr = {6'(v / 10), 6'(h / 10)};
    check("mem_addr", {20'd0, mem_addr}, {20'd0, m_addr});
    if (spots)
      for (int i = 0; i < 7; i++)
        if (c == spot_c[i])
          check("mem_addr_spot", {20'd0, mem_addr}, {20'd0, spot_a[i]});
    if (!vis)
      col = 3'b000;
    else if (busy)
      col = m_last_col;
    else
      col = pattern(m_addr);
    if (vis)
      m_last_col = col;
    fs = (h == 0) && (v == 0);
    if (fs)
      m_uc = busy ? 8'd1 : 8'd0;
    else if (vis && busy && m_uc != 8'd255)
      m_uc = m_uc + 8'd1;
    hs = !((h >= 656) && (h <= 751));
    vs = !((v >= 490) && (v <= 491));
    sb.push_back({hs, vs, vis, fs, col, m_uc});
  endtask

  task automatic run(input int n, input int blo, input int bhi, input bit spots);
    for (int c = 0; c < n; c++) begin
      if (c > 0)
        @(negedge clk);
      cycle_body(c, blo, bhi, spots);
    end
  endtask

  initial begin
    #2;
    mode = 0;
    do_reset();
    // Solid green memory; address walk over lines 0..11.
    run(8940, -1, -1, 1'b1);

    // Asynchronous reset at visible pixel (140,11), then checkerboard with a
    // single write collision at pixel (100,50).
    @(negedge clk);
    mode = 1;
    do_reset();
    run(40400, 50 * 800 + 100, 50 * 800 + 100, 1'b0);
    check("ucnt_after_pulse", {24'd0, underrun_cnt}, 32'd1);

    // Memory busy from reset release through 400 visible pixels: the (0,0)
    // pixel loads 1 and the count saturates at 255.
    @(negedge clk);
    do_reset();
    run(900, 0, 399, 1'b0);
    check("ucnt_saturated", {24'd0, underrun_cnt}, 32'd255);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
